gcd_feeder: RTL and testbench
=============================

GCD_FEEDER -- requirements
Module: gcd_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning operand-pair FIFO entries (power of two, at least 2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1023, meaning the WAIT watchdog limit (used only with the macro in REQ-027).
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  upstream offers an operand pair.
REQ-006 in_ready  output  1  FIFO can accept a pair.
REQ-007 in_a, in_b  input  16 each  operands A and B.
REQ-008 data_in  output  16  serial operand bus to the GCD datapath.
REQ-009 start  output  1  GCD controller start.
REQ-010 done  input  1  GCD controller completion.
REQ-011 result_in  input  16  GCD result, valid while done=1.
REQ-012 out_valid  output  1  result register holds an unconsumed result.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 out_gcd  output  16  result value.
REQ-015 out_err  output  1  result produced by the watchdog, not the GCD.

Function
REQ-016 A push SHALL occur when in_valid=1 and in_ready=1. in_ready=1 iff the FIFO is not full; the FIFO has no fall-through, so a pair pushed at edge N can be popped at edge N+1 at the earliest.
REQ-017 Pointers SHALL wrap modulo DEPTH; the occupancy counter SHALL be DEPTH-capable (clog2(DEPTH)+1 bits). A simultaneous push and pop SHALL leave the count unchanged.
REQ-018 The FSM SHALL have the states IDLE, LOAD_A, LOAD_B, WAIT and RESP.
REQ-019 IDLE: if the FIFO is non-empty and out_valid=0, the FSM SHALL pop the head. If either operand is 0, it SHALL go to RESP with out_gcd=A|B and out_err=0, with no start pulse. Otherwise it SHALL latch A and B and go to LOAD_A.
REQ-020 LOAD_A: the block SHALL drive start=1 and data_in=A for exactly one cycle, then go to LOAD_B.
REQ-021 LOAD_B: the block SHALL drive start=0 and data_in=B for exactly one cycle, then go to WAIT.
REQ-022 WAIT: the block SHALL hold data_in=B. On done=1 it SHALL capture result_in into out_gcd with out_err=0 and go to RESP.
REQ-023 RESP: out_valid SHALL be 1. On out_valid and out_ready it SHALL clear out_valid and return to IDLE; the next pop SHALL occur no earlier than the following cycle.
REQ-024 out_gcd and out_err SHALL be stable while out_valid=1 and out_ready=0.
REQ-025 In IDLE, data_in SHALL be 0 and start SHALL be 0. A done=1 outside WAIT SHALL be ignored.

Reset
REQ-026 On rst=1, regardless of the clock:
- FIFO emptied, in_ready=1
- FSM forced to IDLE
- start=0, data_in=0
- out_valid=0, out_gcd=0, out_err=0
- watchdog cleared
- the in-flight pair discarded, including mid-WAIT
In-flight pairs are not replayed after release.

Configuration
REQ-027 With GCD_FEEDER_TIMEOUT_EN defined:
- a counter SHALL clear on entry to WAIT and increment each WAIT cycle
- when it reaches TIMEOUT_CYCLES with done=0, the FSM SHALL go to RESP with out_gcd=0 and out_err=1
- done=1 in the same cycle SHALL take priority over the timeout
Without the macro there SHALL be no counter, WAIT SHALL wait indefinitely, and out_err SHALL be tied to 0.

Verification
REQ-028 Normal operation: push (1500,192) with out_ready=1.
- Required response: start=1 and data_in=1500 for one cycle, then data_in=192.
- Model returns 12 on done.
- Required result: out_valid=1, out_gcd=12, out_err=0.
REQ-029 Zero bypass: push (0,45), then (45,0).
- Required results: out_gcd=45, then out_gcd=45.
- start SHALL never assert.
REQ-030 Backpressure: hold out_ready=0 and done=0, then push 5 pairs back-to-back.
- Required response: 5 pairs accepted (one in flight plus 4 in the FIFO), then in_ready=0.
- The 6th pair SHALL not be accepted until a pop.
- Results SHALL drain in push order.
REQ-031 Reset mid-operation: assert rst in WAIT with 2 pairs queued.
- Required response: start=0, out_valid=0, in_ready=1 immediately.
- A new pair (36,24) then returns 12.
REQ-032 Result stall: hold out_ready=0 for 10 cycles in RESP.
- out_gcd SHALL stay stable.
- No new start SHALL occur until the handshake completes.
REQ-033 With GCD_FEEDER_TIMEOUT_EN and TIMEOUT_CYCLES=1023: never assert done.
- Required response: out_valid=1, out_gcd=0, out_err=1 after 1023 WAIT cycles.
- A done=1 on cycle 1023 SHALL instead yield the model result with out_err=0.

Source files
------------

// File: rtl/gcd_feeder.sv
// gcd_feeder: queues operand pairs in a small FIFO, feeds them serially to a
// GCD controller (A with start, then B), and holds each result until taken.
// Pairs with a zero operand bypass the controller (result is A|B).
// Optional WAIT watchdog: define GCD_FEEDER_TIMEOUT_EN.
module gcd_feeder #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic [15:0] data_in,
  output logic        start,
  input  logic        done,
  input  logic [15:0] result_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_gcd,
  output logic        out_err
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  // Reject configurations the pointer arithmetic cannot handle.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES == 0) begin : g_bad_param
    $error("gcd_feeder: DEPTH must be a power of two >= 2, TIMEOUT_CYCLES nonzero");
  end

  typedef enum logic [2:0] {StIdle, StLoadA, StLoadB, StWait, StResp} state_e;

  state_e        state_q, state_d;
  logic [15:0]   mem_a [DEPTH];
  logic [15:0]   mem_b [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push, pop;
  logic [15:0]   head_a, head_b;
  logic [15:0]   op_a_q, op_a_d, op_b_q, op_b_d;
  logic [15:0]   gcd_q, gcd_d;

`ifdef GCD_FEEDER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd_q, wd_d;
  logic          err_q, err_d;
  assign out_err = err_q;
`else
  assign out_err = 1'b0;
`endif

  assign in_ready  = (count_q != CW'(DEPTH));
  assign push      = in_valid && in_ready;
  assign head_a    = mem_a[rd_ptr_q];
  assign head_b    = mem_b[rd_ptr_q];
  assign out_valid = (state_q == StResp);
  assign out_gcd   = gcd_q;

  // FIFO storage; no reset needed, occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr_q] <= in_a;
      mem_b[wr_ptr_q] <= in_b;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at power-of-two DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sequencer next state, operand/result capture and datapath drive.
  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    gcd_d   = gcd_q;
    pop     = 1'b0;
    start   = 1'b0;
    data_in = '0;
`ifdef GCD_FEEDER_TIMEOUT_EN
    wd_d    = wd_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (count_q != '0 && !out_valid) begin
          pop = 1'b1;
          if (head_a == '0 || head_b == '0) begin
            gcd_d   = head_a | head_b;
`ifdef GCD_FEEDER_TIMEOUT_EN
            err_d   = 1'b0;
`endif
            state_d = StResp;
          end else begin
            op_a_d  = head_a;
            op_b_d  = head_b;
            state_d = StLoadA;
          end
        end
      end
      StLoadA: begin
        start   = 1'b1;
        data_in = op_a_q;
        state_d = StLoadB;
      end
      StLoadB: begin
        data_in = op_b_q;
        state_d = StWait;
`ifdef GCD_FEEDER_TIMEOUT_EN
        wd_d    = '0;
`endif
      end
      StWait: begin
        data_in = op_b_q;
        if (done) begin
          gcd_d   = result_in;
`ifdef GCD_FEEDER_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = StResp;
        end
`ifdef GCD_FEEDER_TIMEOUT_EN
        // wd_q counts completed WAIT cycles; this cycle brings it to the limit.
        else if (wd_q == TW'(TIMEOUT_CYCLES - 1)) begin
          gcd_d   = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      StResp: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Sequencer state and captured operands/result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      op_a_q  <= '0;
      op_b_q  <= '0;
      gcd_q   <= '0;
`ifdef GCD_FEEDER_TIMEOUT_EN
      wd_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      gcd_q   <= gcd_d;
`ifdef GCD_FEEDER_TIMEOUT_EN
      wd_q    <= wd_d;
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_gcd_feeder.sv
// Self-checking bench for gcd_feeder: directed vector table, hand-written
// corner sequences and a randomized run against a queue-based reference.
module tb_gcd_feeder;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] in_a, in_b;
  logic [15:0] data_in;
  logic        start;
  logic        done = 1'b0;
  logic [15:0] result_in = '0;
  logic        out_valid, out_ready;
  logic [15:0] out_gcd;
  logic        out_err;

  always #5 clk = ~clk;

  gcd_feeder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .data_in   (data_in),
    .start     (start),
    .done      (done),
    .result_in (result_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_gcd   (out_gcd),
    .out_err   (out_err)
  );

  typedef struct { logic [15:0] a; logic [15:0] b; } pair_t;
  typedef struct { logic [15:0] a; logic [15:0] b; logic [15:0] g; } vec_t;

  int          checks = 0;
  int          errors = 0;
  pair_t       exp_q[$];
  pair_t       nz_q[$];
  pair_t       mon_p;
  bit          sb_en = 1'b1;
  bit          hold_done = 1'b0;
  bit          poke_done = 1'b0;
  bit          rand_done = 1'b0;
  int          done_on_wait = 0;
  int          start_cycles = 0;
  int          r_phase = 0;
  int          r_lat = 0;
  int          wait_n = 0;
  logic [15:0] cap_a = '0, cap_b = '0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_gcd = '0;
  logic        prev_err = 1'b0;

  // Reference: Euclid on plain integers; gcd(x,0)=x matches the A|B bypass.
  function automatic logic [15:0] ref_gcd(input logic [15:0] a, input logic [15:0] b);
    int unsigned x = a;
    int unsigned y = b;
    int unsigned t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x[15:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitors plus a behavioural GCD controller, all sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
      nz_q.delete();
      r_phase    = 0;
      done       = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (out_valid && out_ready && sb_en) begin
        if (exp_q.size() == 0) check("sb_unexpected_result", 1, 0);
        else begin
          mon_p = exp_q.pop_front();
          check("sb_gcd", out_gcd, ref_gcd(mon_p.a, mon_p.b));
          check("sb_err", out_err, 0);
        end
      end
      if (prev_stall && out_valid) begin
        check("stall_gcd_stable", out_gcd, prev_gcd);
        check("stall_err_stable", out_err, prev_err);
      end
      prev_stall = out_valid && !out_ready;
      prev_gcd   = out_gcd;
      prev_err   = out_err;
      if (in_valid && in_ready) begin
        exp_q.push_back('{a: in_a, b: in_b});
        if (in_a != 0 && in_b != 0) nz_q.push_back('{a: in_a, b: in_b});
      end
      if (start) start_cycles++;
      case (r_phase)
        0: begin
          done      = poke_done;
          result_in = 16'hdead;
          if (start) begin
            cap_a   = data_in;
            r_phase = 1;
          end
        end
        1: begin
          check("start_one_cycle", start, 0);
          cap_b = data_in;
          if (nz_q.size() == 0) check("load_unexpected", 1, 0);
          else begin
            mon_p = nz_q.pop_front();
            check("load_a", cap_a, mon_p.a);
            check("load_b", cap_b, mon_p.b);
          end
          r_lat   = $urandom_range(0, 4);
          wait_n  = 0;
          r_phase = 2;
        end
        2: begin
          wait_n++;
          if (out_valid) r_phase = 0;  // watchdog ended the transaction
          else begin
            if (wait_n == 1) check("wait_holds_b", data_in, cap_b);
            if (done_on_wait != 0 ? (wait_n == done_on_wait) : (!hold_done && r_lat == 0)) begin
              done      = 1'b1;
              result_in = ref_gcd(cap_a, cap_b);
              r_phase   = 3;
            end else if (r_lat > 0) r_lat--;
          end
        end
        default: begin
          done      = 1'b0;
          result_in = 16'($urandom);
          r_phase   = 0;
        end
      endcase
    end
  end

  task automatic push(input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    while (!in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("push_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, input logic [15:0] g, input int limit);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < limit) begin
      @(negedge clk);
      n++;
    end
    check({name, "_valid"}, out_valid, 1);
    check(name, out_gcd, g);
    check({name, "_err"}, out_err, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic push_random(input int count);
    int unsigned g, ka, kb;
    logic [15:0] ra, rb;
    for (int i = 0; i < count; i++) begin
      g  = $urandom_range(1, 60);
      ka = $urandom_range(0, 30);
      kb = $urandom_range(1, 30);
      if ($urandom_range(0, 7) == 0) ka = 0;
      ra = 16'(g * ka);
      rb = 16'(g * kb);
      if ($urandom_range(0, 5) == 0) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
      end
      push(ra, rb);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    rand_done = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got time %0t, required finish before it", $time);
    $fatal(1);
  end

  initial begin
    vec_t vt[9];
    vec_t bp[5];
    int   s0;
    int   n;
    vt[0] = '{a: 16'd1500,  b: 16'd192,   g: 16'd12};
    vt[1] = '{a: 16'd0,     b: 16'd45,    g: 16'd45};
    vt[2] = '{a: 16'd45,    b: 16'd0,     g: 16'd45};
    vt[3] = '{a: 16'd36,    b: 16'd24,    g: 16'd12};
    vt[4] = '{a: 16'd17,    b: 16'd5,     g: 16'd1};
    vt[5] = '{a: 16'd65535, b: 16'd65535, g: 16'd65535};
    vt[6] = '{a: 16'd0,     b: 16'd0,     g: 16'd0};
    vt[7] = '{a: 16'd48,    b: 16'd18,    g: 16'd6};
    vt[8] = '{a: 16'd1024,  b: 16'd768,   g: 16'd256};
    bp[0] = '{a: 16'd12,  b: 16'd8,  g: 16'd4};
    bp[1] = '{a: 16'd100, b: 16'd75, g: 16'd25};
    bp[2] = '{a: 16'd81,  b: 16'd27, g: 16'd27};
    bp[3] = '{a: 16'd0,   b: 16'd7,  g: 16'd7};
    bp[4] = '{a: 16'd91,  b: 16'd49, g: 16'd7};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_start", start, 0);
    check("rst_data_in", data_in, 0);
    check("rst_out_gcd", out_gcd, 0);
    check("rst_out_err", out_err, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed vectors, one pair at a time with out_ready=1.
    for (int i = 0; i < 9; i++) begin
      s0 = start_cycles;
      push(vt[i].a, vt[i].b);
      wait_result($sformatf("vec%0d_gcd", i), vt[i].g, 300);
      if (vt[i].a == 0 || vt[i].b == 0) check("bypass_no_start", start_cycles, s0);
    end
    @(negedge clk);
    check("idle_start", start, 0);
    check("idle_data_in", data_in, 0);

    // done outside WAIT must be ignored.
    @(posedge clk);
    #1;
    poke_done = 1'b1;
    @(posedge clk);
    #1;
    poke_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stray_done_valid", out_valid, 0);
      check("stray_done_start", start, 0);
    end
    @(posedge clk);
    #1;

    // Backpressure: five back-to-back pairs fit, the sixth waits for a pop.
    out_ready = 1'b0;
    hold_done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_a     = bp[i].a;
      in_b     = bp[i].b;
      @(negedge clk);
      check($sformatf("bp_accept%0d", i), in_ready, 1);
      @(posedge clk);
      #1;
    end
    in_a = 16'd14;
    in_b = 16'd21;
    repeat (3) begin
      @(negedge clk);
      check("bp_full", in_ready, 0);
      @(posedge clk);
      #1;
    end
    // Result stall: first result held 10 cycles with no new start.
    s0        = start_cycles;
    hold_done = 1'b0;
    n         = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("stall_valid", out_valid, 1);
    repeat (10) @(negedge clk);
    check("stall_still_valid", out_valid, 1);
    check("stall_gcd", out_gcd, bp[0].g);
    check("stall_no_start", start_cycles, s0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_sixth_accepted", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain("bp_drained");

    // Reset while in WAIT with two pairs queued.
    hold_done = 1'b1;
    push(16'd30, 16'd12);
    push(16'd9, 16'd6);
    push(16'd10, 16'd4);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("pre_rst_wait_data", data_in, 12);
    rst = 1'b1;
    #1;
    check("midrst_start", start, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_data_in", data_in, 0);
    hold_done = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    push(16'd36, 16'd24);
    wait_result("post_rst_36_24", 16'd12, 300);
    repeat (20) @(negedge clk);
    check("post_rst_no_replay", out_valid, 0);
    check("post_rst_queue_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;

    // Randomized pairs with random downstream backpressure.
    fork
      push_random(30);
      begin
        int k = 0;
        while (!rand_done && k < 5000) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
          k++;
        end
      end
    join
    drain("rand_drained");

`ifdef GCD_FEEDER_TIMEOUT_EN
    // Watchdog: done never comes.
    out_ready = 1'b0;
    hold_done = 1'b1;
    sb_en     = 1'b0;
    push(16'd1500, 16'd192);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 1100) begin
      n++;
      @(negedge clk);
    end
    // 3 cycles (IDLE, LOAD_A, LOAD_B) plus 1023 WAIT cycles before RESP.
    check("wd_latency", n, 1026);
    check("wd_gcd", out_gcd, 0);
    check("wd_err", out_err, 1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    sb_en = 1'b1;
    // done on WAIT cycle 1023 wins over the watchdog.
    done_on_wait = 1023;
    push(16'd1500, 16'd192);
    wait_result("wd_done_priority", 16'd12, 1200);
    done_on_wait = 0;
    hold_done    = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
